// File: rtl/seg7_scan.sv
// Four-digit multiplexed 7-segment driver for an HH:MM clock.
// Digits are snapshotted once per frame so the display never shows a torn time.
module seg7_scan #(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       tick_i,
    input  logic [3:0] digit0_i,
    input  logic [3:0] digit1_i,
    input  logic [3:0] digit2_i,
    input  logic [3:0] digit3_i,
    output logic [6:0] seg_o,
    output logic [3:0] an_o,
    output logic       colon_o
);

    localparam int unsigned CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [3:0][3:0]   snap_q, snap_d;
    logic              colon_st_q, colon_st_d;
    logic [6:0]        seg_q, seg_d;
    logic [3:0]        an_q, an_d;
    logic              colon_q, colon_d;
    logic              tc;
    logic [3:0]        cur_digit;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        case (d)
            4'd0:    bcd_to_seg = 7'h3F;
            4'd1:    bcd_to_seg = 7'h06;
            4'd2:    bcd_to_seg = 7'h5B;
            4'd3:    bcd_to_seg = 7'h4F;
            4'd4:    bcd_to_seg = 7'h66;
            4'd5:    bcd_to_seg = 7'h6D;
            4'd6:    bcd_to_seg = 7'h7D;
            4'd7:    bcd_to_seg = 7'h07;
            4'd8:    bcd_to_seg = 7'h7F;
            4'd9:    bcd_to_seg = 7'h6F;
            default: bcd_to_seg = 7'h40;
        endcase
    endfunction

    // Next-state: prescaler, scan index, frame snapshot, colon and display registers.
    always_comb begin
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        snap_d     = snap_q;
        colon_st_d = colon_st_q;
        seg_d      = seg_q;
        an_d       = an_q;
        cur_digit  = 4'd0;

        tc = (cnt_q == TC_VAL);
        cnt_d = tc ? '0 : cnt_q + CNT_W'(1);

        if (tc) begin
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
                snap_d = {digit3_i, digit2_i, digit1_i, digit0_i};
            end
        end

        colon_st_d = colon_st_q ^ tick_i;
        colon_d    = colon_st_d & en_i;

        // Blanking applies on any edge; re-enable waits for the next slot boundary.
        cur_digit = snap_d[idx_d];
        if (!en_i) begin
            an_d  = 4'hF;
            seg_d = 7'h00;
        end else if (tc) begin
            an_d  = ~(4'b0001 << idx_d);
            seg_d = ((idx_d == 2'd3) && (cur_digit == 4'd0)) ? 7'h00 : bcd_to_seg(cur_digit);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            idx_q      <= 2'd3;
            snap_q     <= '0;
            colon_st_q <= 1'b0;
            seg_q      <= 7'h00;
            an_q       <= 4'hF;
            colon_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            snap_q     <= snap_d;
            colon_st_q <= colon_st_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
            colon_q    <= colon_d;
        end
    end

    assign seg_o   = seg_q;
    assign an_o    = an_q;
    assign colon_o = colon_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan: stimulus queues expected display states per edge,
// a monitor pops and compares them just after each clock edge or on reset assertion.
module tb_seg7_scan;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       en_i = 1'b1;
    logic       tick_i = 1'b0;
    logic [3:0] digit0_i = 4'd0;
    logic [3:0] digit1_i = 4'd0;
    logic [3:0] digit2_i = 4'd0;
    logic [3:0] digit3_i = 4'd0;
    logic [6:0] seg_o;
    logic [3:0] an_o;
    logic       colon_o;

    seg7_scan #(.SCAN_DIV(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .tick_i(tick_i),
        .digit0_i(digit0_i), .digit1_i(digit1_i), .digit2_i(digit2_i), .digit3_i(digit3_i),
        .seg_o(seg_o), .an_o(an_o), .colon_o(colon_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int unsigned cyc;
        bit          imm;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        colon;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int unsigned base = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    bit          done = 1'b0;
    bit          flushed = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic void exp_at(input int unsigned n, input logic [3:0] an,
                                   input logic [6:0] seg, input logic colon, input string nm);
        exp_t e;
        e.cyc = base + n; e.imm = 1'b0; e.an = an; e.seg = seg; e.colon = colon; e.name = nm;
        sb.push_back(e);
    endfunction

    function automatic void exp_now(input string nm);
        exp_t e;
        e.cyc = 0; e.imm = 1'b1; e.an = 4'hF; e.seg = 7'h00; e.colon = 1'b0; e.name = nm;
        sb.push_back(e);
    endfunction

    // Monitor: compares queued expectations against the DUT.
    always begin
        exp_t e;
        @(posedge clk_i or posedge rst_i);
        #1;
        while (sb.size() != 0) begin
            e = sb[0];
            if (e.imm && !rst_i) break;
            if (!e.imm && e.cyc > cyc) break;
            void'(sb.pop_front());
            n_tests++;
            if (!e.imm && e.cyc < cyc) begin
                n_fail++;
                $display("FAIL %s: expectation for edge %0d not checked (now %0d)", e.name, e.cyc, cyc);
            end else if (an_o !== e.an || seg_o !== e.seg || colon_o !== e.colon) begin
                n_fail++;
                $display("FAIL %s: edge %0d an_o=%h seg_o=%h colon_o=%b, required an_o=%h seg_o=%h colon_o=%b",
                         e.name, cyc, an_o, seg_o, colon_o, e.an, e.seg, e.colon);
            end
        end
        if (done && !flushed) begin
            while (sb.size() != 0) begin
                e = sb.pop_front();
                n_tests++;
                n_fail++;
                $display("FAIL %s: never checked (timeout), required an_o=%h seg_o=%h", e.name, e.an, e.seg);
            end
            flushed = 1'b1;
        end
    end

    task automatic wait_to(input int unsigned n);
        while (cyc < base + n) @(negedge clk_i);
    endtask

    initial begin
        digit0_i = 4'd3; digit1_i = 4'd4; digit2_i = 4'd2; digit3_i = 4'd1;
        exp_now("reset_initial");
        #1 rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        base = cyc;

        // 12:43 scan, then digit0 change mid-frame
        exp_at(2,  4'hF, 7'h00, 1'b0, "pre_first_tc");
        exp_at(4,  4'hE, 7'h4F, 1'b0, "d0_3");
        exp_at(8,  4'hD, 7'h66, 1'b0, "d1_4");
        exp_at(12, 4'hB, 7'h5B, 1'b0, "d2_2");
        exp_at(16, 4'h7, 7'h06, 1'b0, "d3_1");
        exp_at(20, 4'hE, 7'h4F, 1'b0, "d0_wrap");
        exp_at(22, 4'hE, 7'h4F, 1'b0, "mid_slot_hold");
        exp_at(24, 4'hD, 7'h66, 1'b0, "d1_frame2");
        exp_at(28, 4'hB, 7'h5B, 1'b0, "d2_after_change");
        exp_at(32, 4'h7, 7'h06, 1'b0, "d3_after_change");
        exp_at(36, 4'hE, 7'h07, 1'b0, "d0_new_7");
        wait_to(25);
        digit0_i = 4'd7;

        // 09:05 with leading-zero blank
        wait_to(37);
        digit0_i = 4'd5; digit1_i = 4'd0; digit2_i = 4'd9; digit3_i = 4'd0;
        exp_at(40, 4'hD, 7'h66, 1'b0, "old_frame_d1");
        exp_at(44, 4'hB, 7'h5B, 1'b0, "old_frame_d2");
        exp_at(48, 4'h7, 7'h06, 1'b0, "old_frame_d3");
        exp_at(52, 4'hE, 7'h6D, 1'b0, "d0_5");
        exp_at(56, 4'hD, 7'h3F, 1'b0, "d1_0");
        exp_at(60, 4'hB, 7'h6F, 1'b0, "d2_9");
        exp_at(64, 4'h7, 7'h00, 1'b0, "lead_zero_blank");

        // dash decode and enable gating
        wait_to(65);
        digit1_i = 4'd12;
        exp_at(68, 4'hE, 7'h6D, 1'b0, "d0_5_again");
        exp_at(72, 4'hD, 7'h40, 1'b0, "dash_12");
        exp_at(76, 4'hF, 7'h00, 1'b0, "en_low_blank");
        exp_at(78, 4'hF, 7'h00, 1'b0, "en_high_wait_tc");
        exp_at(80, 4'h7, 7'h00, 1'b0, "index_advanced");
        exp_at(84, 4'hE, 7'h6D, 1'b0, "en_restored");
        wait_to(75);
        en_i = 1'b0;
        wait_to(76);
        en_i = 1'b1;

        // colon ticks, including one on a TC edge
        exp_at(86, 4'hE, 7'h6D, 1'b1, "colon_1");
        exp_at(90, 4'hD, 7'h40, 1'b0, "colon_0");
        exp_at(94, 4'hB, 7'h6F, 1'b1, "colon_1b");
        exp_at(96, 4'h7, 7'h00, 1'b0, "tick_on_tc");
        exp_at(98, 4'h7, 7'h00, 1'b1, "colon_1c");
        exp_at(100, 4'hE, 7'h6D, 1'b1, "colon_held_d0");
        exp_at(108, 4'hB, 7'h6F, 1'b1, "idx2_before_rst");
        wait_to(85); tick_i = 1'b1;
        wait_to(86); tick_i = 1'b0;
        wait_to(89); tick_i = 1'b1;
        wait_to(90); tick_i = 1'b0;
        wait_to(93); tick_i = 1'b1;
        wait_to(94); tick_i = 1'b0;
        wait_to(95); tick_i = 1'b1;
        wait_to(96); tick_i = 1'b0;
        wait_to(97); tick_i = 1'b1;
        wait_to(98); tick_i = 1'b0;

        // asynchronous reset mid-slot at index 2
        wait_to(108);
        exp_now("async_reset");
        #2 rst_i = 1'b1;
        digit0_i = 4'd8; digit1_i = 4'd6; digit2_i = 4'd3; digit3_i = 4'd2;
        @(negedge clk_i);
        rst_i = 1'b0;
        base = cyc;
        exp_at(2,  4'hF, 7'h00, 1'b0, "post_rst_blank");
        exp_at(4,  4'hE, 7'h7F, 1'b0, "post_rst_d0_8");
        exp_at(8,  4'hD, 7'h7D, 1'b0, "post_rst_d1_6");
        exp_at(12, 4'hB, 7'h4F, 1'b0, "post_rst_d2_3");
        exp_at(16, 4'h7, 7'h5B, 1'b0, "post_rst_d3_2");
        wait_to(20);

        done = 1'b1;
        repeat (5) @(negedge clk_i);
        if (!flushed) begin
            n_tests++;
            n_fail++;
            $display("FAIL monitor_flush: flushed=%b, required 1", flushed);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 Parameter SCAN_DIV, default 4, SHALL give the clk_i cycles each digit is shown; legal range 2..65535.
REQ-002 clk_i  input  1  system clock, rising-edge active.
REQ-003 rst_i  input  1  reset: one clock; reset is asynchronous and active-high.
REQ-004 en_i  input  1  display enable; low blanks all outputs while scanning continues.
REQ-005 tick_i  input  1  one-cycle 1 Hz pulse; toggles the colon.
REQ-006 digit0_i  input  4  minutes units, BCD (xx:xm).
REQ-007 digit1_i  input  4  minutes tens, BCD (xx:mx).
REQ-008 digit2_i  input  4  hours units, BCD (xh:xx), from the 24 h counter.
REQ-009 digit3_i  input  4  hours tens, BCD (hx:xx), from the 24 h counter.
REQ-010 seg_o  output  7  segments, active-high; bit0=a ... bit6=g.
REQ-011 an_o  output  4  digit select, one-hot active-low; bit n = digit n.
REQ-012 colon_o  output  1  colon LED, active-high.

Function
REQ-013 Prescaler SHALL count 0..SCAN_DIV-1 and wrap to 0; terminal count (TC) = value SCAN_DIV-1.
REQ-014 2-bit index SHALL advance by 1 mod 4 on each TC edge and hold otherwise.
REQ-015 On a TC edge where index wraps 3->0, all four digit inputs SHALL be captured into a snapshot register; inputs are not sampled at any other time.
REQ-016 Digit shown at index 0 in the wrap cycle SHALL be the value captured on that same edge (no stale frame).
REQ-017 seg_o and an_o SHALL be registers updated on the TC edge from the new index and snapshot; latency input-to-display = 1 clk after capture.
REQ-018 an_o SHALL drive exactly one 0 at bit = index while en_i=1; never two digits active.
REQ-019 BCD decode (hex seg_o): 0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F.
REQ-020 Codes 10..15 SHALL decode to 40 (dash, g only).
REQ-021 Leading-zero blank: at index 3, snapshot digit3=0 SHALL give seg_o=00 with an_o still active.
REQ-022 Colon state SHALL toggle on each clk edge with tick_i=1; colon_o = state AND en_i.
REQ-023 en_i=0 SHALL force an_o=F and seg_o=00 on the next edge; prescaler, index, snapshot, colon state keep running.
REQ-024 en_i rising SHALL restore normal outputs at the next TC edge, not mid-slot.
REQ-025 tick_i coincident with TC SHALL both take effect on the same edge.
REQ-026 No output may glitch: all outputs come directly from flops.

Reset
REQ-027 rst_i=1 SHALL immediately (no clock) set prescaler=0, index=3, snapshot=0, colon state=0, an_o=F, seg_o=00, colon_o=0.
REQ-028 Reset mid-scan SHALL discard the current frame; after release the first TC wraps index to 0 and captures fresh inputs.
REQ-029 First valid digit SHALL appear SCAN_DIV edges after rst_i deasserts.

Verification
REQ-030 SCAN_DIV=4, en_i=1, digits {3,4,2,1} (12:43) after reset -> edge 4: an_o=E,seg_o=4F; edge 8: D,66; edge 12: B,5B; edge 16: 7,06; edge 20: E,4F.
REQ-031 Digits 09:05 -> index 3 shows an_o=7, seg_o=00 (blanked zero); index 2 shows 6F.
REQ-032 Change digit0_i from 3 to 7 during index 1 -> display keeps 4F until next wrap, then shows 07 at index 0.
REQ-033 digit1_i=12 -> seg_o=40 at index 1; en_i=0 one cycle before a TC -> an_o=F, seg_o=00, colon_o=0 next edge; index still advances.
REQ-034 Three tick_i pulses -> colon_o 1,0,1; tick_i on a TC edge -> colon toggles and digit advances same edge.
REQ-035 Assert rst_i asynchronously mid-slot at index 2 -> outputs F/00/0 before next clk edge; first digit at edge SCAN_DIV after release.
